mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between instruction fetch and the memory stage (loads and stores leaving execute).
- Arbitrates requests, locks the port while a request is pending, and tracks up to MAX_OUTSTANDING in-order transactions so each response returns to its owner.
- Discards fetch responses killed by a pipeline flush (branch, jump or trap).

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_tag_fifo.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and tag layout for the memory-port arbiter and its tag FIFO.
package mem_arb_pkg;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef struct packed {
        logic owner;
        logic drop;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order owner/drop tag FIFO; flush_fetch marks every fetch-owned entry as dropped.
module mem_arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic                     pop,
    input  logic                     flush_fetch,
    output logic [TAG_W-1:0]         head_tag,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    tag_t             entries [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].drop <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush_fetch && entries[i].owner == OWNER_FETCH) begin
                    entries[i].drop <= 1'b1;
                end
            end
            // The pushed tag already carries a same-cycle flush, so it overrides the loop.
            if (push) begin
                entries[wptr] <= tag_t'(push_tag);
                wptr          <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head_tag = entries[rptr];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data; optional fetch anti-starvation
// under the MEM_ARB_FAIRNESS_EN macro.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req_valid,
    output logic        fetch_req_ready,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_flush,
    output logic        fetch_rsp_valid,
    output logic [31:0] fetch_rsp_data,
    output logic        fetch_rsp_error,
    input  logic        data_req_valid,
    output logic        data_req_ready,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic        data_we,
    input  logic [1:0]  data_size,
    output logic        data_rsp_valid,
    output logic [31:0] data_rsp_data,
    output logic        data_rsp_error,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_error
);

    if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 ||
        STARVE_LIMIT < 1) begin : g_param_check
        $error("mem_port_arbiter: MAX_OUTSTANDING must be a power of 2 >= 2, STARVE_LIMIT >= 1");
    end

    logic                             state_q;
    logic                             owner_q;
    logic                             sel_owner;
    logic                             force_fetch;
    logic                             has_room;
    logic                             req_live;
    logic                             accept;
    logic                             pop;
    logic [TAG_W-1:0]                 push_tag;
    logic [TAG_W-1:0]                 head_tag;
    tag_t                             head;
    logic                             tag_full;
    logic                             tag_empty;
    logic [$clog2(MAX_OUTSTANDING):0] tag_count_unused;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else if (!fetch_req_valid || (accept && sel_owner == OWNER_FETCH)) begin
            starve_q <= '0;
        end else if (accept && sel_owner == OWNER_DATA &&
                     starve_q != STARVE_W'(STARVE_LIMIT)) begin
            starve_q <= starve_q + 1'b1;
        end
    end

    assign force_fetch = (starve_q == STARVE_W'(STARVE_LIMIT));
`else
    assign force_fetch = 1'b0;
`endif

    always_comb begin
        if (state_q == ST_LOCKED) begin
            sel_owner = owner_q;
        end else if (force_fetch && fetch_req_valid) begin
            sel_owner = OWNER_FETCH;
        end else if (data_req_valid) begin
            sel_owner = OWNER_DATA;
        end else begin
            sel_owner = OWNER_FETCH;
        end
    end

    // A response popping this cycle frees a slot, so a full FIFO can still admit one request.
    assign pop      = mem_rsp_valid && !tag_empty && !reset;
    assign has_room = (state_q == ST_LOCKED) || !tag_full || pop;
    assign req_live = has_room && !reset;

    assign mem_req_valid   = req_live && ((sel_owner == OWNER_DATA) ? data_req_valid : fetch_req_valid);
    assign fetch_req_ready = req_live && (sel_owner == OWNER_FETCH) && mem_req_ready;
    assign data_req_ready  = req_live && (sel_owner == OWNER_DATA) && mem_req_ready;
    assign accept          = mem_req_valid && mem_req_ready;

    assign mem_addr  = (sel_owner == OWNER_DATA) ? data_addr  : fetch_addr;
    assign mem_wdata = (sel_owner == OWNER_DATA) ? data_wdata : 32'h0;
    assign mem_we    = (sel_owner == OWNER_DATA) && data_we;
    assign mem_size  = (sel_owner == OWNER_DATA) ? data_size  : SIZE_WORD;

    assign push_tag = {sel_owner, (sel_owner == OWNER_FETCH) && fetch_flush};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWNER_FETCH;
        end else if (state_q == ST_IDLE) begin
            if (mem_req_valid && !mem_req_ready) begin
                state_q <= ST_LOCKED;
                owner_q <= sel_owner;
            end
        end else if (accept) begin
            state_q <= ST_IDLE;
        end
    end

    mem_arb_tag_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (accept),
        .push_tag    (push_tag),
        .pop         (pop),
        .flush_fetch (fetch_flush),
        .head_tag    (head_tag),
        .full        (tag_full),
        .empty       (tag_empty),
        .count       (tag_count_unused)
    );

    assign head = tag_t'(head_tag);

    assign fetch_rsp_valid = pop && head.owner == OWNER_FETCH && !head.drop && !fetch_flush;
    assign data_rsp_valid  = pop && head.owner == OWNER_DATA;
    assign fetch_rsp_data  = mem_rsp_data;
    assign fetch_rsp_error = mem_rsp_error;
    assign data_rsp_data   = mem_rsp_data;
    assign data_rsp_error  = mem_rsp_error;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter; honours MEM_ARB_FAIRNESS_EN when defined.
module tb_mem_port_arbiter;

    localparam logic [31:0] FA = 32'h0000_0040;
    localparam logic [31:0] DA = 32'h0000_0100;
`ifdef MEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_req_valid = 1'b0, fetch_req_ready, fetch_flush = 1'b0;
    logic [31:0] fetch_addr = FA;
    logic        fetch_rsp_valid, fetch_rsp_error;
    logic [31:0] fetch_rsp_data;
    logic        data_req_valid = 1'b0, data_req_ready;
    logic [31:0] data_addr = DA, data_wdata = 32'h1234_5678;
    logic        data_we = 1'b0;
    logic [1:0]  data_size = 2'b10;
    logic        data_rsp_valid, data_rsp_error;
    logic [31:0] data_rsp_data;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_rsp_valid = 1'b0, mem_rsp_error = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
        .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data),
        .fetch_rsp_error(fetch_rsp_error),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_we(data_we),
        .data_size(data_size),
        .data_rsp_valid(data_rsp_valid), .data_rsp_data(data_rsp_data),
        .data_rsp_error(data_rsp_error),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_size(mem_size),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_error(mem_rsp_error)
    );

    typedef struct {
        logic        rst, fv, dv, mr, rv, fl;
        logic [31:0] rd;
        logic        mv;
        logic [31:0] ma;
        logic        fr, dr, frv, drv;
        int          cnt;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input logic rst, fv, dv, mr, rv, fl, input logic [31:0] rd,
                                input logic mv, input logic [31:0] ma,
                                input logic fr, dr, frv, drv, input int cnt);
        vec_t v;
        v.rst = rst; v.fv = fv; v.dv = dv; v.mr = mr; v.rv = rv; v.fl = fl; v.rd = rd;
        v.mv = mv; v.ma = ma; v.fr = fr; v.dr = dr; v.frv = frv; v.drv = drv; v.cnt = cnt;
        return v;
    endfunction

    task automatic check_vec(input int idx, input vec_t v);
        logic [31:0] act_ma, act_rd, exp_rd;
        act_ma = mem_req_valid ? mem_addr : 32'h0;
        act_rd = fetch_rsp_valid ? fetch_rsp_data : (data_rsp_valid ? data_rsp_data : 32'h0);
        exp_rd = (v.frv || v.drv) ? v.rd : 32'h0;
        n_vec++;
        if ({mem_req_valid, act_ma, fetch_req_ready, data_req_ready, fetch_rsp_valid,
             data_rsp_valid, act_rd} !== {v.mv, v.ma, v.fr, v.dr, v.frv, v.drv, exp_rd}) begin
            n_miss++;
            $display("FAIL vec%0d: got mv=%b ma=%h fr=%b dr=%b frv=%b drv=%b rd=%h, want mv=%b ma=%h fr=%b dr=%b frv=%b drv=%b rd=%h",
                     idx, mem_req_valid, act_ma, fetch_req_ready, data_req_ready, fetch_rsp_valid,
                     data_rsp_valid, act_rd, v.mv, v.ma, v.fr, v.dr, v.frv, v.drv, exp_rd);
        end
        if (v.cnt >= 0) begin
            n_vec++;
            if (int'(dut.u_tag_fifo.count) != v.cnt) begin
                n_miss++;
                $display("FAIL count%0d: got %0d, want %0d", idx, dut.u_tag_fifo.count, v.cnt);
            end
        end
    endtask

    initial begin
        //        rst fv dv mr rv fl rd             mv ma  fr dr frv drv cnt
        vq.push_back(mk(1, 1, 1, 1, 1, 0, 32'h0,   0, 0,  0, 0, 0, 0, -1)); // reset forces outputs low
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   0, 0,  0, 0, 0, 0, -1));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 32'h0,   1, DA, 0, 1, 0, 0,  0)); // data beats fetch
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0,   1, FA, 1, 0, 0, 0, -1));
        vq.push_back(mk(0, 0, 0, 1, 1, 0, 32'hAA,  0, 0,  1, 0, 0, 1, -1)); // responses in order
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'hBB,  0, 0,  0, 0, 1, 0, -1));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,   1, FA, 0, 0, 0, 0,  0)); // fetch locks the port
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,   1, FA, 0, 0, 0, 0, -1));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,   1, FA, 0, 0, 0, 0, -1));
        vq.push_back(mk(0, 1, 1, 1, 0, 0, 32'h0,   1, FA, 1, 0, 0, 0, -1));
        vq.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0,   1, DA, 0, 1, 0, 0, -1));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h1,   0, 0,  0, 0, 1, 0, -1));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h2,   0, 0,  0, 0, 0, 1, -1));
        for (int i = 0; i < 4; i++)                                              // fill to the limit
            vq.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0, 1, FA, 1, 0, 0, 0, i));
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0,   0, 0,  0, 0, 0, 0,  4));
        vq.push_back(mk(0, 1, 0, 1, 1, 0, 32'h3,   1, FA, 1, 0, 1, 0,  4)); // admitted on the pop
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h4 + i, 0, 0, 0, 0, 1, 0, 4 - i));
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0,   1, FA, 1, 0, 0, 0,  0)); // flush kills fetches
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0,   1, FA, 1, 0, 0, 0, -1));
        vq.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0,   1, DA, 0, 1, 0, 0, -1));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 32'h0,   0, 0,  0, 0, 0, 0,  3));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h10,  0, 0,  0, 0, 0, 0, -1));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h11,  0, 0,  0, 0, 0, 0, -1));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h12,  0, 0,  0, 0, 0, 1, -1));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h13,  0, 0,  0, 0, 0, 0,  0)); // empty FIFO response
        for (int i = 0; i < 3; i++)                                              // reset with 3 in flight
            vq.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0, 1, FA, 1, 0, 0, 0, 0 + i));
        vq.push_back(mk(1, 1, 0, 1, 1, 0, 32'h20,  0, 0,  0, 0, 0, 0,  3));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h21,  0, 0,  0, 0, 0, 0,  0));
        vq.push_back(mk(0, 1, 0, 1, 0, 1, 32'h0,   1, FA, 1, 0, 0, 0, -1)); // flush on push cycle
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h22,  0, 0,  0, 0, 0, 0,  1));
        vq.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0,   1, FA, 1, 0, 0, 0,  0));
        vq.push_back(mk(0, 0, 0, 0, 1, 1, 32'h23,  0, 0,  0, 0, 0, 0,  1)); // flush on pop cycle
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,   1, FA, 0, 0, 0, 0,  0)); // flush while locked on fetch
        vq.push_back(mk(0, 1, 1, 1, 0, 1, 32'h0,   1, FA, 1, 0, 0, 0, -1));
        vq.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0,   1, DA, 0, 1, 0, 0, -1));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h24,  0, 0,  0, 0, 0, 0,  2));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h25,  0, 0,  0, 0, 0, 1, -1));
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 32'h0,   1, DA, 0, 0, 0, 0,  0)); // flush while locked on data
        vq.push_back(mk(0, 1, 1, 1, 0, 1, 32'h0,   1, DA, 0, 1, 0, 0, -1));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 32'h26,  0, 0,  0, 0, 0, 1,  1));

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            reset = vq[i].rst; fetch_req_valid = vq[i].fv; data_req_valid = vq[i].dv;
            mem_req_ready = vq[i].mr; mem_rsp_valid = vq[i].rv; fetch_flush = vq[i].fl;
            mem_rsp_data = vq[i].rd;
            #4;
            check_vec(i, vq[i]);
        end

        // Both requesters continuously valid: grant pattern over ten cycles.
        for (int k = 0; k < 10; k++) begin
            logic exp_f;
            @(posedge clk); #1;
            reset = 1'b0; fetch_req_valid = 1'b1; data_req_valid = 1'b1; mem_req_ready = 1'b1;
            fetch_flush = 1'b0; mem_rsp_valid = (k != 0); mem_rsp_data = 32'h100 + k;
            #4;
            exp_f = FAIR && (k % 5 == 4);
            n_vec++;
            if ({fetch_req_ready, data_req_ready, mem_req_valid} !== {exp_f, !exp_f, 1'b1}) begin
                n_miss++;
                $display("FAIL grant%0d: got fr=%b dr=%b mv=%b, want fr=%b dr=%b mv=1",
                         k, fetch_req_ready, data_req_ready, mem_req_valid, exp_f, !exp_f);
            end
        end

        @(posedge clk); #1;
        fetch_req_valid = 1'b0; data_req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
